// File: rtl/mb_chan_resp_if.sv
// mb_chan_resp_if: DMA20 channel word-request and memory bus bundle
//  slave  : responder side (mb_chan_resp)
//  master : CCW logic / memory side driving requests and memory handshakes
interface mb_chan_resp_if #(parameter int ADR_W = 22);
  logic [3:0]       ccw_wd_req_h;
  logic             ccw_mem_store_ena_h;
  logic [ADR_W-1:0] ccw_cha_h;
  logic             ch_mb_req_inh_h;
  logic [35:0]      chan_wr_data_h;
  logic             mem_ack_h;
  logic             mem_rd_valid_h;
  logic [36:0]      mem_rd_data_h;
  logic             mem_wr_rdy_h;
  logic             err_clr_l;
  logic             mem_start_h;
  logic             mem_wr_h;
  logic [ADR_W-1:0] mem_adr_h;
  logic [3:0]       mem_wd_mask_h;
  logic [36:0]      mem_wr_data_h;
  logic [3:0]       mb_hold_in_h;
  logic [35:0]      chan_rd_data_h;
  logic [1:0]       wd_idx_h;
  logic             ccl_wd_taken_h;
  logic             resp_busy_h;
  logic             ccl_mem_err_latch_l;
  logic             err_nxm_h;
  logic             err_par_h;
  modport slave (
    input  ccw_wd_req_h, ccw_mem_store_ena_h, ccw_cha_h, ch_mb_req_inh_h, chan_wr_data_h,
           mem_ack_h, mem_rd_valid_h, mem_rd_data_h, mem_wr_rdy_h, err_clr_l,
    output mem_start_h, mem_wr_h, mem_adr_h, mem_wd_mask_h, mem_wr_data_h, mb_hold_in_h,
           chan_rd_data_h, wd_idx_h, ccl_wd_taken_h, resp_busy_h, ccl_mem_err_latch_l,
           err_nxm_h, err_par_h
  );
  modport master (
    output ccw_wd_req_h, ccw_mem_store_ena_h, ccw_cha_h, ch_mb_req_inh_h, chan_wr_data_h,
           mem_ack_h, mem_rd_valid_h, mem_rd_data_h, mem_wr_rdy_h, err_clr_l,
    input  mem_start_h, mem_wr_h, mem_adr_h, mem_wd_mask_h, mem_wr_data_h, mb_hold_in_h,
           chan_rd_data_h, wd_idx_h, ccl_wd_taken_h, resp_busy_h, ccl_mem_err_latch_l,
           err_nxm_h, err_par_h
  );
endinterface

// File: rtl/mb_chan_resp.sv
// mb_chan_resp: memory-side responder for DMA20 channel quadword word requests
//  clk_mb_h   : clock, rising edge
//  mr_reset_l : asynchronous active-low reset
//  bus        : mb_chan_resp_if.slave (requests, memory handshake, read/store data, error status)
//  MB_CHAN_PAR_EN : when defined, read words are checked for odd parity and flag err_par_h
module mb_chan_resp #(
  parameter int TMO_CYC = 64,
  parameter int ADR_W   = 22
) (
  input logic           clk_mb_h,
  input logic           mr_reset_l,
  mb_chan_resp_if.slave bus
);
  localparam int CW = $clog2(TMO_CYC + 1);
  typedef enum logic [2:0] {IDLE, START, WAIT, XFER, DONE} state_t;
  state_t state, nxt;
  logic [3:0] mask, rem, rem_n, hold;
  logic [ADR_W-1:0] adr;
  logic [CW-1:0] cnt;
  logic [35:0] rd_data;
  logic [1:0] idx;
  logic wr, rd_tk, nxm, par, acc, tmo, mv;
  function automatic logic [1:0] low(input logic [3:0] m);
    return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
  endfunction
  always_comb begin
    acc   = |bus.ccw_wd_req_h && !bus.ch_mb_req_inh_h && !(nxm || par);
    tmo   = cnt == CW'(TMO_CYC - 1);
    mv    = state == XFER && (wr ? bus.mem_wr_rdy_h : bus.mem_rd_valid_h);
    rem_n = rem & ~(4'b1 << idx);
    nxt   = state;
    case (state)
      IDLE:    nxt = acc ? START : IDLE;
      START:   nxt = WAIT;
      WAIT:    nxt = bus.mem_ack_h ? XFER : tmo ? DONE : WAIT;
      XFER:    nxt = mv && rem_n == 4'b0 ? DONE : XFER;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_mb_h or negedge mr_reset_l)
    if (!mr_reset_l) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk_mb_h or negedge mr_reset_l)
    if (!mr_reset_l) begin
      mask    <= '0;
      rem     <= '0;
      adr     <= '0;
      wr      <= 1'b0;
      cnt     <= '0;
      idx     <= '0;
      hold    <= '0;
      rd_tk   <= 1'b0;
      rd_data <= '0;
      nxm     <= 1'b0;
      par     <= 1'b0;
    end else begin
      hold  <= '0;
      rd_tk <= 1'b0;
      cnt   <= state == WAIT ? cnt + CW'(1) : '0;
      if (state == IDLE && acc) begin
        mask <= bus.ccw_wd_req_h;
        adr  <= bus.ccw_cha_h & ~ADR_W'(3);
        wr   <= bus.ccw_mem_store_ena_h;
      end
      if (state == DONE) mask <= '0;
      if (state == WAIT && bus.mem_ack_h) begin
        rem <= mask;
        idx <= low(mask);
      end
      if (mv) begin
        rem <= rem_n;
        if (|rem_n) idx <= low(rem_n);
      end
      if (mv && !wr) begin
        rd_data <= bus.mem_rd_data_h[35:0];
        hold    <= 4'b1 << idx;
        rd_tk   <= 1'b1;
      end
      if (!bus.err_clr_l) begin
        nxm <= 1'b0;
        par <= 1'b0;
      end
      if (state == WAIT && !bus.mem_ack_h && tmo) nxm <= 1'b1;
`ifdef MB_CHAN_PAR_EN
      if (mv && !wr && !(^bus.mem_rd_data_h)) par <= 1'b1;
`endif
    end
`ifndef MB_CHAN_PAR_EN
  logic unused_par;
  assign unused_par = bus.mem_rd_data_h[36];
`endif
  assign bus.mem_start_h         = state == START;
  assign bus.mem_wr_h            = wr;
  assign bus.mem_adr_h           = adr;
  assign bus.mem_wd_mask_h       = mask;
  assign bus.mem_wr_data_h       = state == XFER && wr ? {~^bus.chan_wr_data_h, bus.chan_wr_data_h} : '0;
  assign bus.mb_hold_in_h        = hold;
  assign bus.chan_rd_data_h      = rd_data;
  assign bus.wd_idx_h            = idx;
  assign bus.ccl_wd_taken_h      = rd_tk || (mv && wr);
  assign bus.resp_busy_h         = state != IDLE;
  assign bus.ccl_mem_err_latch_l = !(nxm || par);
  assign bus.err_nxm_h           = nxm;
  assign bus.err_par_h           = par;
endmodule

// File: tb/tb_mb_chan_resp.sv
// tb_mb_chan_resp: scoreboard bench for mb_chan_resp
module tb_mb_chan_resp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int passed = 0;
  logic [39:0] rq[$];
  logic [38:0] wq[$];
  mb_chan_resp_if #(.ADR_W(22)) bus();
  mb_chan_resp #(.TMO_CYC(64), .ADR_W(22)) dut (.clk_mb_h(clk), .mr_reset_l(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic req(input logic [3:0] m, input logic st, input logic [21:0] cha);
    bus.ccw_wd_req_h = m;
    bus.ccw_mem_store_ena_h = st;
    bus.ccw_cha_h = cha;
    tick();
    bus.ccw_wd_req_h = 4'b0;
  endtask
  task automatic test_reset();
    tick(2);
    total++; if (bus.resp_busy_h !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.resp_busy_h); else passed++;
    total++; if (bus.ccl_mem_err_latch_l !== 1'b1) $display("FAIL rst_latch: got %b want 1", bus.ccl_mem_err_latch_l); else passed++;
    total++; if ({bus.mem_start_h, bus.mem_wr_h, bus.mem_wd_mask_h, bus.mb_hold_in_h, bus.ccl_wd_taken_h} !== 11'b0)
      $display("FAIL rst_ctl: got %b want 0", {bus.mem_start_h, bus.mem_wr_h, bus.mem_wd_mask_h, bus.mb_hold_in_h, bus.ccl_wd_taken_h}); else passed++;
    total++; if ({bus.mem_adr_h, bus.wd_idx_h, bus.err_nxm_h, bus.err_par_h} !== 26'b0)
      $display("FAIL rst_misc: got %h want 0", {bus.mem_adr_h, bus.wd_idx_h, bus.err_nxm_h, bus.err_par_h}); else passed++;
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_read();
    logic [35:0] d;
    logic [39:0] e;
    int tk = 0;
    req(4'b1111, 1'b0, 22'h01234F);
    total++; if (bus.mem_start_h !== 1'b1) $display("FAIL rd_start: got %b want 1", bus.mem_start_h); else passed++;
    total++; if (bus.mem_adr_h !== 22'h01234C) $display("FAIL rd_adr: got %h want 01234c", bus.mem_adr_h); else passed++;
    total++; if ({bus.mem_wr_h, bus.mem_wd_mask_h} !== 5'b01111) $display("FAIL rd_dirmask: got %b want 01111", {bus.mem_wr_h, bus.mem_wd_mask_h}); else passed++;
    tick();
    total++; if (bus.mem_start_h !== 1'b0) $display("FAIL rd_start_once: got %b want 0", bus.mem_start_h); else passed++;
    tick();
    bus.mem_ack_h = 1'b1;
    tick();
    bus.mem_ack_h = 1'b0;
    total++; if (bus.wd_idx_h !== 2'd0) $display("FAIL rd_idx0: got %0d want 0", bus.wd_idx_h); else passed++;
    for (int i = 0; i < 4; i++) begin
      d = {4'($urandom()), 32'($urandom())};
      bus.mem_rd_valid_h = 1'b1;
      bus.mem_rd_data_h = {~^d, d};
      rq.push_back({4'b1 << i, d});
      tick();
      tk += int'(bus.ccl_wd_taken_h);
      total++;
      if (rq.size() == 0 || bus.mb_hold_in_h === 4'b0) $display("FAIL rd_word%0d: got no strobe want one", i);
      else begin
        e = rq.pop_front();
        if ({bus.mb_hold_in_h, bus.chan_rd_data_h} !== e) $display("FAIL rd_word%0d: got %h want %h", i, {bus.mb_hold_in_h, bus.chan_rd_data_h}, e); else passed++;
      end
    end
    bus.mem_rd_valid_h = 1'b0;
    total++; if (tk != 4) $display("FAIL rd_taken: got %0d want 4", tk); else passed++;
    total++; if (bus.resp_busy_h !== 1'b1) $display("FAIL rd_done_busy: got %b want 1", bus.resp_busy_h); else passed++;
    tick();
    total++; if ({bus.resp_busy_h, bus.mem_wd_mask_h} !== 5'b0) $display("FAIL rd_idle: got %b want 0", {bus.resp_busy_h, bus.mem_wd_mask_h}); else passed++;
  endtask
  task automatic test_store();
    logic [35:0] d;
    logic [38:0] e;
    int tk = 0;
    req(4'b0101, 1'b1, 22'h3FFFFF);
    total++; if ({bus.mem_start_h, bus.mem_wr_h, bus.mem_adr_h} !== {2'b11, 22'h3FFFFC})
      $display("FAIL st_start: got %h want %h", {bus.mem_start_h, bus.mem_wr_h, bus.mem_adr_h}, {2'b11, 22'h3FFFFC}); else passed++;
    tick();
    bus.mem_ack_h = 1'b1;
    tick();
    bus.mem_ack_h = 1'b0;
    bus.mem_wr_rdy_h = 1'b1;
    for (int i = 0; i < 2; i++) begin
      d = i == 0 ? 36'h0 : {4'($urandom()), 32'($urandom())};
      bus.chan_wr_data_h = d;
      wq.push_back({i == 0 ? 2'd0 : 2'd2, ~^d, d});
      #1;
      tk += int'(bus.ccl_wd_taken_h);
      total++;
      if (wq.size() == 0 || !bus.ccl_wd_taken_h) $display("FAIL st_word%0d: got no taken want one", i);
      else begin
        e = wq.pop_front();
        if ({bus.wd_idx_h, bus.mem_wr_data_h} !== e) $display("FAIL st_word%0d: got %h want %h", i, {bus.wd_idx_h, bus.mem_wr_data_h}, e); else passed++;
      end
      if (i == 0) begin
        total++; if (bus.mem_wr_data_h[36] !== 1'b1) $display("FAIL st_par0: got %b want 1", bus.mem_wr_data_h[36]); else passed++;
      end
      tick();
    end
    #1;
    tk += int'(bus.ccl_wd_taken_h);
    total++; if (tk != 2) $display("FAIL st_taken: got %0d want 2", tk); else passed++;
    total++; if (bus.resp_busy_h !== 1'b1) $display("FAIL st_done: got %b want 1", bus.resp_busy_h); else passed++;
    bus.mem_wr_rdy_h = 1'b0;
    tick();
    total++; if (bus.resp_busy_h !== 1'b0) $display("FAIL st_idle: got %b want 0", bus.resp_busy_h); else passed++;
  endtask
  task automatic test_timeout();
    logic [35:0] d;
    logic [39:0] e;
    req(4'b0001, 1'b0, 22'h000010);
    tick(64);
    total++; if (bus.ccl_mem_err_latch_l !== 1'b1) $display("FAIL tmo_early: got %b want 1", bus.ccl_mem_err_latch_l); else passed++;
    tick();
    total++; if ({bus.err_nxm_h, bus.ccl_mem_err_latch_l, bus.resp_busy_h} !== 3'b101)
      $display("FAIL tmo_err: got %b want 101", {bus.err_nxm_h, bus.ccl_mem_err_latch_l, bus.resp_busy_h}); else passed++;
    tick();
    bus.ccw_wd_req_h = 4'b0011;
    bus.ccw_mem_store_ena_h = 1'b0;
    tick(3);
    total++; if ({bus.resp_busy_h, bus.err_nxm_h} !== 2'b01) $display("FAIL tmo_holdoff: got %b want 01", {bus.resp_busy_h, bus.err_nxm_h}); else passed++;
    bus.err_clr_l = 1'b0;
    tick();
    bus.err_clr_l = 1'b1;
    total++; if ({bus.err_nxm_h, bus.ccl_mem_err_latch_l} !== 2'b01) $display("FAIL tmo_clr: got %b want 01", {bus.err_nxm_h, bus.ccl_mem_err_latch_l}); else passed++;
    tick();
    bus.ccw_wd_req_h = 4'b0;
    total++; if (bus.mem_start_h !== 1'b1) $display("FAIL tmo_accept: got %b want 1", bus.mem_start_h); else passed++;
    tick(64);
    bus.mem_ack_h = 1'b1;
    tick();
    bus.mem_ack_h = 1'b0;
    total++; if ({bus.err_nxm_h, bus.ccl_mem_err_latch_l, bus.wd_idx_h} !== 4'b0100)
      $display("FAIL tmo_ack64: got %b want 0100", {bus.err_nxm_h, bus.ccl_mem_err_latch_l, bus.wd_idx_h}); else passed++;
    for (int i = 0; i < 2; i++) begin
      d = {4'($urandom()), 32'($urandom())};
      bus.mem_rd_valid_h = 1'b1;
      bus.mem_rd_data_h = {~^d, d};
      rq.push_back({4'b1 << i, d});
      tick();
      total++;
      if (rq.size() == 0 || bus.mb_hold_in_h === 4'b0) $display("FAIL tmo_word%0d: got no strobe want one", i);
      else begin
        e = rq.pop_front();
        if ({bus.mb_hold_in_h, bus.chan_rd_data_h} !== e) $display("FAIL tmo_word%0d: got %h want %h", i, {bus.mb_hold_in_h, bus.chan_rd_data_h}, e); else passed++;
      end
    end
    bus.mem_rd_valid_h = 1'b0;
    tick();
  endtask
  task automatic test_parity();
    logic [35:0] d;
    logic [39:0] e;
    req(4'b1111, 1'b0, 22'h000200);
    tick();
    bus.mem_ack_h = 1'b1;
    tick();
    bus.mem_ack_h = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = {4'($urandom()), 32'($urandom())};
      bus.mem_rd_valid_h = 1'b1;
      bus.mem_rd_data_h = i == 1 ? {^d, d} : {~^d, d};
      rq.push_back({4'b1 << i, d});
      tick();
      total++;
      if (rq.size() == 0 || bus.mb_hold_in_h === 4'b0) $display("FAIL par_word%0d: got no strobe want one", i);
      else begin
        e = rq.pop_front();
        if ({bus.mb_hold_in_h, bus.chan_rd_data_h} !== e) $display("FAIL par_word%0d: got %h want %h", i, {bus.mb_hold_in_h, bus.chan_rd_data_h}, e); else passed++;
      end
    end
    bus.mem_rd_valid_h = 1'b0;
`ifdef MB_CHAN_PAR_EN
    total++; if ({bus.err_par_h, bus.ccl_mem_err_latch_l} !== 2'b10) $display("FAIL par_err: got %b want 10", {bus.err_par_h, bus.ccl_mem_err_latch_l}); else passed++;
`else
    total++; if ({bus.err_par_h, bus.ccl_mem_err_latch_l} !== 2'b01) $display("FAIL par_err: got %b want 01", {bus.err_par_h, bus.ccl_mem_err_latch_l}); else passed++;
`endif
    tick();
    bus.err_clr_l = 1'b0;
    tick();
    bus.err_clr_l = 1'b1;
    total++; if ({bus.err_par_h, bus.ccl_mem_err_latch_l} !== 2'b01) $display("FAIL par_clr: got %b want 01", {bus.err_par_h, bus.ccl_mem_err_latch_l}); else passed++;
  endtask
  task automatic test_reset_mid();
    logic [35:0] d;
    logic [39:0] e;
    req(4'b1111, 1'b0, 22'h000100);
    tick();
    bus.mem_ack_h = 1'b1;
    tick();
    bus.mem_ack_h = 1'b0;
    d = {4'($urandom()), 32'($urandom())};
    bus.mem_rd_valid_h = 1'b1;
    bus.mem_rd_data_h = {~^d, d};
    rq.push_back({4'b0001, d});
    tick();
    total++;
    if (rq.size() == 0 || bus.mb_hold_in_h === 4'b0) $display("FAIL rm_word0: got no strobe want one");
    else begin
      e = rq.pop_front();
      if ({bus.mb_hold_in_h, bus.chan_rd_data_h} !== e) $display("FAIL rm_word0: got %h want %h", {bus.mb_hold_in_h, bus.chan_rd_data_h}, e); else passed++;
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({bus.resp_busy_h, bus.mb_hold_in_h, bus.ccl_wd_taken_h, bus.mem_wd_mask_h, bus.wd_idx_h, bus.chan_rd_data_h} !== 48'b0)
      $display("FAIL rm_async: got %h want 0", {bus.resp_busy_h, bus.mb_hold_in_h, bus.ccl_wd_taken_h, bus.mem_wd_mask_h, bus.wd_idx_h, bus.chan_rd_data_h}); else passed++;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if ({bus.mb_hold_in_h, bus.ccl_wd_taken_h, bus.resp_busy_h} !== 6'b0)
        $display("FAIL rm_nostrobe%0d: got %b want 0", i, {bus.mb_hold_in_h, bus.ccl_wd_taken_h, bus.resp_busy_h}); else passed++;
    end
    bus.mem_rd_valid_h = 1'b0;
    req(4'b0010, 1'b0, 22'h000104);
    total++; if ({bus.mem_start_h, bus.mem_wd_mask_h} !== 5'b10010) $display("FAIL rm_restart: got %b want 10010", {bus.mem_start_h, bus.mem_wd_mask_h}); else passed++;
    tick();
    bus.mem_ack_h = 1'b1;
    tick();
    bus.mem_ack_h = 1'b0;
    d = {4'($urandom()), 32'($urandom())};
    bus.mem_rd_valid_h = 1'b1;
    bus.mem_rd_data_h = {~^d, d};
    rq.push_back({4'b0010, d});
    tick();
    bus.mem_rd_valid_h = 1'b0;
    total++;
    if (rq.size() == 0 || bus.mb_hold_in_h === 4'b0) $display("FAIL rm_word1: got no strobe want one");
    else begin
      e = rq.pop_front();
      if ({bus.mb_hold_in_h, bus.chan_rd_data_h} !== e) $display("FAIL rm_word1: got %h want %h", {bus.mb_hold_in_h, bus.chan_rd_data_h}, e); else passed++;
    end
    tick();
    bus.ch_mb_req_inh_h = 1'b1;
    bus.ccw_wd_req_h = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if ({bus.resp_busy_h, bus.mem_start_h} !== 2'b0) $display("FAIL inh%0d: got %b want 00", i, {bus.resp_busy_h, bus.mem_start_h}); else passed++;
    end
    bus.ccw_wd_req_h = 4'b0;
    bus.ch_mb_req_inh_h = 1'b0;
  endtask
  initial begin
    bus.ccw_wd_req_h = 4'b0;
    bus.ccw_mem_store_ena_h = 1'b0;
    bus.ccw_cha_h = 22'h0;
    bus.ch_mb_req_inh_h = 1'b0;
    bus.chan_wr_data_h = 36'h0;
    bus.mem_ack_h = 1'b0;
    bus.mem_rd_valid_h = 1'b0;
    bus.mem_rd_data_h = 37'h0;
    bus.mem_wr_rdy_h = 1'b0;
    bus.err_clr_l = 1'b1;
    test_reset();
    test_read();
    test_store();
    test_timeout();
    test_parity();
    test_reset_mid();
    total++; if (rq.size() != 0 || wq.size() != 0) $display("FAIL sb_empty: got %0d/%0d left want 0", rq.size(), wq.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
